cache_ctrl_fsm: RTL and testbench
=================================

// Module: cache_ctrl_fsm
// PURPOSE
//  Sequencing controller for the two-level hierarchy (2-line fully associative L1, 8-bit words).
//  Holds the tag/valid/dirty/LRU/data state and the FSM:
//  - accepts CPU read/write requests over a ready/done handshake;
//  - resolves hit/miss;
//  - on a miss, issues write-back and refill transactions to the RAM over a req/ack port.
//  Replaces the free-running "act on every clock edge" scheme with an explicit one-request-at-a-time scheduler.
// PARAMETERS
//  ADDR_W  8  address width (tag = full address, 1 word per line)
//  DATA_W  8  data word width
//  CNT_W   8  width of the hit/miss/write-back statistics counters
// PORTS
//  clock         in   1       single clock; all state updates on rising edge
//  reset         in   1       synchronous, active-high
//  cpu_req       in   1       request valid
//  cpu_write     in   1       1 = write, 0 = read (sampled on accept)
//  cpu_address   in   ADDR_W  request address (sampled on accept)
//  cpu_dataIn    in   DATA_W  write data (sampled on accept)
//  cpu_ready     out  1       1 only in IDLE; accept = cpu_req & cpu_ready
//  cpu_done      out  1       1-cycle pulse: request complete
//  cpu_dataOut   out  DATA_W  read data, valid while cpu_done=1
//  cpu_hit       out  1       hit flag of the completed request, valid while cpu_done=1
//  ram_req       out  1       RAM transaction pending
//  ram_write     out  1       1 = write-back, 0 = refill read
//  ram_address   out  ADDR_W  RAM address
//  ram_dataOut   out  DATA_W  write-back data to RAM
//  ram_dataIn    in   DATA_W  refill data from RAM (sampled on ack cycle)
//  ram_ack       in   1       completes the pending transaction
//  hit_count, miss_count, wb_count  out  CNT_W  saturating statistics
// BEHAVIOUR
//  Reset (sync): state=IDLE; all lines valid=0, dirty=0, LRU=0, tag/data=0.
//   Outputs after reset: cpu_ready=1; cpu_done, cpu_hit, ram_req, ram_write = 0;
//   data/address outputs = 0; counters = 0.
//   Reset mid-transaction aborts it immediately: ram_req drops the next cycle and dirty data is discarded.
//  States: IDLE -> LOOKUP -> {DONE | WRITEBACK | REFILL}; WRITEBACK -> REFILL|DONE; REFILL -> DONE; DONE -> IDLE.
//  - IDLE: on accept, capture write/address/dataIn; go to LOOKUP. cpu_req while cpu_ready=0 is ignored (not queued).
//  - LOOKUP: hit = valid & tag==address on either line.
//    - Read hit: dataOut <= line data.
//    - Write hit: line data <= dataIn, dirty <= 1.
//    - Either hit -> DONE; hit_count++.
//    - Miss: miss_count++.
//      Victim = lowest-index invalid line; else the line with LRU=0.
//      Victim valid & dirty -> WRITEBACK.
//      Otherwise: read -> REFILL; write -> install (tag, data, valid=1, dirty=1) -> DONE. No RAM access on a write miss.
//  - WRITEBACK: ram_req=1, ram_write=1, ram_address=victim tag, ram_dataOut=victim data, held stable until ram_ack.
//    On ack: wb_count++; victim dirty <= 0; read -> REFILL; write -> install as above -> DONE.
//  - REFILL: ram_req=1, ram_write=0, ram_address=captured address.
//    On ack: install tag, data=ram_dataIn, valid=1, dirty=0; cpu_dataOut <= ram_dataIn -> DONE.
//  - DONE: cpu_done=1 for exactly 1 cycle, cpu_hit = LOOKUP result -> IDLE.
//  RAM handshake:
//   - ram_ack is only honoured while ram_req=1; ack with ram_req=0 is ignored.
//   - ack on the first cycle of ram_req is legal.
//   - ram_req deasserts the cycle after ack; back-to-back WRITEBACK->REFILL drops ram_req for >=1 cycle.
//  LRU: accessed/installed line LRU<=1, other line LRU<=0, updated in the cycle that resolves the request.
//  Latency (accept cycle = 0):
//   - hit / clean write miss: cpu_done at cycle 2;
//   - read miss: cycle 3 + RAM wait cycles per transaction (+1 between transactions when a write-back is needed).
//  Counters saturate at 2^CNT_W-1, never wrap.
//  No simultaneous-event conflict exists: only one request is in flight at a time.
// TESTING
//  1 Reset, then read 0x02; RAM acks 1 cycle later with 0x01 -> one refill at ram_address=0x02;
//    done with dataOut=0x01, hit=0; line0 holds tag 0x02, clean; miss_count=1.
//  2 Read 0x02 again -> done at cycle 2, dataOut=0x01, hit=1, no ram_req; hit_count=1.
//  3 Write 0x03 (data 0xAA) -> installed in line1 (invalid), dirty, hit=0, no RAM traffic, done at cycle 2.
//    Then write 0x00 (data 0x55) -> evicts line0 (LRU=0, clean), no write-back.
//  4 Read 0x01 -> victim line1 (dirty): write-back addr=0x03 data=0xAA, then refill addr=0x01,
//    ram_req low >=1 cycle between them; wb_count=1.
//  5 Assert reset during WRITEBACK with ram_ack held low -> next cycle ram_req=0, cpu_ready=1, all lines invalid.
//    A later ram_ack=1 is ignored.
//  6 Issue 300 alternating hits -> hit_count saturates at 0xFF.
//    cpu_req pulsed while busy is dropped: cpu_done count equals the accept count.

Source files
------------

// File: rtl/cache_ctrl_fsm_if.sv
// CPU request/response and RAM transaction signals of the L1 cache controller.
// The slave side is the controller; the master side is the CPU plus RAM.
interface cache_ctrl_fsm_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_address;
    logic [DATA_W-1:0] cpu_dataIn;
    logic              cpu_ready;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_dataOut;
    logic              cpu_hit;
    logic              ram_req;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_dataOut;
    logic [DATA_W-1:0] ram_dataIn;
    logic              ram_ack;

    modport slave (
        input  cpu_req, cpu_write, cpu_address, cpu_dataIn, ram_dataIn, ram_ack,
        output cpu_ready, cpu_done, cpu_dataOut, cpu_hit,
               ram_req, ram_write, ram_address, ram_dataOut
    );

    modport master (
        output cpu_req, cpu_write, cpu_address, cpu_dataIn, ram_dataIn, ram_ack,
        input  cpu_ready, cpu_done, cpu_dataOut, cpu_hit,
               ram_req, ram_write, ram_address, ram_dataOut
    );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// Two-line fully associative L1 controller: one CPU request in flight,
// dirty victims written back and read misses refilled over the RAM port.
module cache_ctrl_fsm #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    cache_ctrl_fsm_if.slave  bus,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0][ADDR_W-1:0] tag_q, tag_d;
    logic [1:0][DATA_W-1:0] data_q, data_d;
    logic [1:0]             valid_q, valid_d;
    logic [1:0]             dirty_q, dirty_d;
    logic [1:0]             lru_q, lru_d;
    logic                   wr_q, wr_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      din_q, din_d;
    logic [DATA_W-1:0]      dout_q, dout_d;
    logic                   hit_q, hit_d;
    logic                   vic_q, vic_d;
    logic                   gap_q, gap_d;
    logic [CNT_W-1:0]       hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]       miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]       wb_cnt_q, wb_cnt_d;

    logic [1:0]        match;
    logic              hit_idx, victim, ram_req, ack;
    logic              inst_en, inst_idx, inst_dirty;
    logic [DATA_W-1:0] inst_data;
    logic              touch_en, touch_idx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        match[0] = valid_q[0] && (tag_q[0] == addr_q);
        match[1] = valid_q[1] && (tag_q[1] == addr_q);
        hit_idx  = ~match[0];
        // Lowest invalid line first; with both valid, the line whose LRU bit is 0.
        if (!valid_q[0])      victim = 1'b0;
        else if (!valid_q[1]) victim = 1'b1;
        else                  victim = lru_q[0];
        // gap_q keeps ram_req low for one cycle between write-back and refill.
        ram_req = (state_q == S_WRITEBACK) || ((state_q == S_REFILL) && !gap_q);
        ack     = ram_req && bus.ram_ack;
    end

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        data_d     = data_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        lru_d      = lru_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        din_d      = din_q;
        dout_d     = dout_q;
        hit_d      = hit_q;
        vic_d      = vic_q;
        gap_d      = gap_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        inst_en    = 1'b0;
        inst_idx   = vic_q;
        inst_dirty = 1'b0;
        inst_data  = din_q;
        touch_en   = 1'b0;
        touch_idx  = vic_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    wr_d    = bus.cpu_write;
                    addr_d  = bus.cpu_address;
                    din_d   = bus.cpu_dataIn;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit_d = |match;
                if (|match) begin
                    hit_cnt_d = sat_inc(hit_cnt_q);
                    touch_en  = 1'b1;
                    touch_idx = hit_idx;
                    if (wr_q) begin
                        data_d[hit_idx]  = din_q;
                        dirty_d[hit_idx] = 1'b1;
                    end else begin
                        dout_d = data_q[hit_idx];
                    end
                    state_d = S_DONE;
                end else begin
                    miss_cnt_d = sat_inc(miss_cnt_q);
                    vic_d      = victim;
                    if (valid_q[victim] && dirty_q[victim]) begin
                        state_d = S_WRITEBACK;
                    end else if (wr_q) begin
                        inst_en    = 1'b1;
                        inst_idx   = victim;
                        inst_dirty = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_REFILL;
                    end
                end
            end
            S_WRITEBACK: begin
                if (ack) begin
                    wb_cnt_d       = sat_inc(wb_cnt_q);
                    dirty_d[vic_q] = 1'b0;
                    if (wr_q) begin
                        inst_en    = 1'b1;
                        inst_dirty = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        gap_d   = 1'b1;
                        state_d = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                gap_d = 1'b0;
                if (ack) begin
                    inst_en   = 1'b1;
                    inst_data = bus.ram_dataIn;
                    dout_d    = bus.ram_dataIn;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (inst_en) begin
            tag_d[inst_idx]   = addr_q;
            data_d[inst_idx]  = inst_data;
            valid_d[inst_idx] = 1'b1;
            dirty_d[inst_idx] = inst_dirty;
            touch_en          = 1'b1;
            touch_idx         = inst_idx;
        end
        if (touch_en) begin
            lru_d[touch_idx]  = 1'b1;
            lru_d[~touch_idx] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tag_q      <= '0;
            data_q     <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
            lru_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            dout_q     <= '0;
            hit_q      <= 1'b0;
            vic_q      <= 1'b0;
            gap_q      <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            lru_q      <= lru_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            dout_q     <= dout_d;
            hit_q      <= hit_d;
            vic_q      <= vic_d;
            gap_q      <= gap_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    always_comb begin
        bus.cpu_ready   = (state_q == S_IDLE);
        bus.cpu_done    = (state_q == S_DONE);
        bus.cpu_hit     = hit_q;
        bus.cpu_dataOut = dout_q;
        bus.ram_req     = ram_req;
        bus.ram_write   = (state_q == S_WRITEBACK);
        bus.ram_address = '0;
        bus.ram_dataOut = '0;
        if (state_q == S_WRITEBACK) begin
            bus.ram_address = tag_q[vic_q];
            bus.ram_dataOut = data_q[vic_q];
        end else if (state_q == S_REFILL) begin
            bus.ram_address = addr_q;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
    assign wb_count   = wb_cnt_q;
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm: randomized CPU traffic and RAM wait states against
// a timestamp-LRU cache model and a shadow of architected memory contents.
module tb_cache_ctrl_fsm;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] hit_count, miss_count, wb_count;
    logic       rsp_ack = 1'b0;
    logic       man_ack = 1'b0;

    cache_ctrl_fsm_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    assign bus.ram_ack = rsp_ack | man_ack;

    cache_ctrl_fsm #(.ADDR_W(8), .DATA_W(8), .CNT_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus.slave),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          v;
        bit          d;
        bit [7:0]    tag;
        bit [7:0]    data;
        int unsigned ts;
    } line_t;
    typedef struct {
        bit       wr;
        bit [7:0] addr;
        bit [7:0] data;
        int       w;
    } txn_t;

    line_t       ln[2];
    txn_t        txq[$];
    logic [7:0]  mem[256];
    logic [7:0]  shadow[256];
    int          n_cmp = 0, n_err = 0;
    int          done_cnt = 0, exp_done = 0;
    int          hc, mc, wc;
    int unsigned tick;
    bit          ram_en = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) ln[i] = '{1'b0, 1'b0, 8'h00, 8'h00, 0};
        hc = 0; mc = 0; wc = 0; tick = 0;
        // Dirty lines are lost on reset, so the architected state is whatever RAM holds.
        for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    endtask

    // RAM responder: random 0..2 wait cycles, one-cycle ack, logs each transaction.
    initial begin
        bit   busy;
        int   cnt, w;
        txn_t cur;
        busy = 1'b0; cnt = 0; w = 0;
        cur = '{1'b0, 8'h00, 8'h00, 0};
        forever begin
            @(negedge clock);
            if (rsp_ack) begin
                rsp_ack = 1'b0;
                chk("ram_req_drop", bus.ram_req, 0);
            end else if (ram_en && bus.ram_req) begin
                if (!busy) begin
                    busy = 1'b1; cnt = 0; w = $urandom_range(0, 2);
                    cur = '{bus.ram_write, bus.ram_address, bus.ram_dataOut, w};
                end
                if (cnt == w) begin
                    chk("ram_hold", {bus.ram_write, bus.ram_address, bus.ram_dataOut},
                        {cur.wr, cur.addr, cur.data});
                    if (cur.wr) mem[cur.addr] = cur.data;
                    else bus.ram_dataIn = mem[cur.addr];
                    txq.push_back(cur);
                    rsp_ack = 1'b1;
                    busy = 1'b0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (bus.cpu_done) done_cnt++;
    end

    task automatic do_req(input bit wr, input bit [7:0] a, input bit [7:0] d, input bit noise);
        int       hi, vic, lat, exp_lat, n_exp;
        bit       got, exp_wb, exp_rf;
        bit [7:0] exp_q;
        hi = -1;
        for (int i = 0; i < 2; i++) if (ln[i].v && ln[i].tag == a) hi = i;
        vic = -1;
        for (int i = 0; i < 2; i++) if (vic < 0 && !ln[i].v) vic = i;
        if (vic < 0) vic = (ln[0].ts < ln[1].ts) ? 0 : 1;
        exp_wb = (hi < 0) && ln[vic].v && ln[vic].d;
        exp_rf = (hi < 0) && !wr;
        n_exp  = int'(exp_wb) + int'(exp_rf);
        exp_q  = shadow[a];
        txq.delete();

        chk("ready", bus.cpu_ready, 1);
        bus.cpu_req = 1'b1; bus.cpu_write = wr; bus.cpu_address = a; bus.cpu_dataIn = d;
        got = 1'b0; lat = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clock);
            lat++;
            if (bus.cpu_done) got = 1'b1;
            else if (noise) begin
                bus.cpu_req     = 1'($urandom_range(0, 1));
                bus.cpu_write   = 1'($urandom_range(0, 1));
                bus.cpu_address = 8'($urandom);
                bus.cpu_dataIn  = 8'($urandom);
            end else bus.cpu_req = 1'b0;
        end
        bus.cpu_req = 1'b0;
        exp_done++;
        chk("done_seen", got, 1);
        chk("hit", bus.cpu_hit, hi >= 0);
        if (!wr) chk("rdata", bus.cpu_dataOut, exp_q);
        chk("ram_txns", txq.size(), n_exp);
        if (txq.size() == n_exp) begin
            exp_lat = 2;
            if (exp_wb) begin
                chk("wb_txn", {txq[0].wr, txq[0].addr, txq[0].data}, {1'b1, ln[vic].tag, ln[vic].data});
                exp_lat += 1 + txq[0].w;
            end
            if (exp_rf) begin
                chk("rf_txn", {txq[$].wr, txq[$].addr}, {1'b0, a});
                exp_lat += 1 + txq[$].w;
            end
            if (exp_wb && exp_rf) exp_lat++;
            chk("latency", lat, exp_lat);
        end

        tick++;
        if (hi >= 0) begin
            hc++;
            ln[hi].ts = tick;
            if (wr) begin ln[hi].data = d; ln[hi].d = 1'b1; end
        end else begin
            mc++;
            if (exp_wb) wc++;
            ln[vic] = '{1'b1, wr, a, wr ? d : exp_q, tick};
        end
        if (wr) shadow[a] = d;
        chk("hit_cnt", hit_count, sat(hc));
        chk("miss_cnt", miss_count, sat(mc));
        chk("wb_cnt", wb_count, sat(wc));

        @(negedge clock);
        chk("done_pulse", {bus.cpu_done, bus.cpu_ready}, 2'b01);
    endtask

    initial begin
        bit seen;
        bus.cpu_req = 1'b0; bus.cpu_write = 1'b0; bus.cpu_address = '0; bus.cpu_dataIn = '0;
        bus.ram_dataIn = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[2] = 8'h01;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        model_reset();
        chk("rst_cpu", {bus.cpu_ready, bus.cpu_done, bus.cpu_hit, bus.cpu_dataOut}, {3'b100, 8'h00});
        chk("rst_ram", {bus.ram_req, bus.ram_write, bus.ram_address, bus.ram_dataOut}, 18'h0);
        chk("rst_cnt", {hit_count, miss_count, wb_count}, 24'h0);

        // Refill, hit, clean write misses, dirty eviction with write-back then refill.
        do_req(1'b0, 8'h02, 8'h00, 1'b0);
        chk("t1_data", bus.cpu_dataOut, 8'h01);
        do_req(1'b0, 8'h02, 8'h00, 1'b0);
        do_req(1'b1, 8'h03, 8'hAA, 1'b0);
        do_req(1'b1, 8'h00, 8'h55, 1'b0);
        do_req(1'b0, 8'h01, 8'h00, 1'b0);
        chk("t4_wb_count", wb_count, 1);

        // Reset while a write-back waits for ack.
        ram_en = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_address = 8'h04;
        @(negedge clock);
        bus.cpu_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            seen = bus.ram_req;
        end
        chk("t5_wb_req", seen, 1);
        chk("t5_wb", {bus.ram_write, bus.ram_address, bus.ram_dataOut}, {1'b1, 8'h00, 8'h55});
        @(negedge clock);
        chk("t5_wait", bus.ram_req, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t5_abort", {bus.ram_req, bus.cpu_ready, bus.cpu_done}, 3'b010);
        chk("t5_cnt", {hit_count, miss_count, wb_count}, 24'h0);
        man_ack = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("t5_ack_ignored", {bus.ram_req, bus.cpu_ready, bus.cpu_done}, 3'b010);
        end
        man_ack = 1'b0;
        ram_en = 1'b1;
        model_reset();
        do_req(1'b0, 8'h01, 8'h00, 1'b0);
        chk("t5_lines_invalid", bus.cpu_hit, 0);

        // Random mix over a small address set to force hits, misses and evictions.
        for (int i = 0; i < 200; i++)
            do_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 5)), 8'($urandom), 1'b1);

        // Hit-counter saturation with busy-time request noise.
        do_req(1'b0, 8'h10, 8'h00, 1'b1);
        do_req(1'b0, 8'h11, 8'h00, 1'b1);
        for (int i = 0; i < 300; i++) do_req(1'b0, (i % 2) ? 8'h11 : 8'h10, 8'h00, 1'b1);
        chk("hit_sat", hit_count, 8'hFF);
        repeat (3) @(negedge clock);
        chk("done_count", done_cnt, exp_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
